// File: rtl/div_iter.sv
// div_iter: multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// Operands are latched on an accepted start. A start is accepted whenever
// busy is low, which is the IDLE and DONE states. After that, one quotient
// bit is resolved per clock. The result is returned in C together with a
// one-cycle done strobe. Division by zero and signed overflow are resolved
// at accept time, so the block goes straight to DONE for those cases.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous reset, active-high (priority over everything)
//   start - request a division; sampled only while busy = 0
//   op    - 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   A     - dividend, sampled with start
//   B     - divisor, sampled with start
//   C     - quotient or remainder; holds until the next result loads
//   busy  - high while iterating (CALC state)
//   done  - one-cycle strobe, C valid in this cycle
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic [XLEN-1:0] C,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Two's-complement negate, modulo 2^XLEN.
    function automatic logic [XLEN-1:0] neg2(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Negate when the sign flag is set, pass through otherwise.
    function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v,
                                                   input logic            neg);
        logic [XLEN-1:0] r;
        if (neg) begin
            r = neg2(v);
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t          state_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] divisor_r;
    logic            neg_q_r;
    logic            neg_r_r;
    logic            op_rem_r;
    logic [CW-1:0]   cnt_r;

    logic            signed_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic [XLEN-1:0] a_mag_s;
    logic [XLEN-1:0] b_mag_s;
    logic            div_zero_s;
    logic            ovf_s;
    logic            special_s;
    logic [XLEN-1:0] special_c_s;

    logic [XLEN:0]   shifted_s;
    logic [XLEN:0]   trial_s;
    logic [XLEN-1:0] rem_nx_s;
    logic [XLEN-1:0] quo_nx_s;
    logic [XLEN-1:0] result_s;

    // Operand preparation and special-case detection for an accept this cycle.
    always_comb begin
        signed_s   = ~op[0];
        a_neg_s    = signed_s & A[XLEN-1];
        b_neg_s    = signed_s & B[XLEN-1];
        if (a_neg_s) begin
            a_mag_s = neg2(A);
        end else begin
            a_mag_s = A;
        end
        if (b_neg_s) begin
            b_mag_s = neg2(B);
        end else begin
            b_mag_s = B;
        end
        div_zero_s = (B == ZERO);
        ovf_s      = signed_s & (A == MIN_NEG) & (B == ONES);
        special_s  = div_zero_s | ovf_s;
        if (div_zero_s) begin
            special_c_s = op[1] ? A : ONES;
        end else if (ovf_s) begin
            special_c_s = op[1] ? ZERO : MIN_NEG;
        end else begin
            special_c_s = ZERO;
        end
    end

    // One restoring step. The partial remainder always stays below the
    // divisor, so the shifted value is below 2*divisor. When the trial
    // subtraction is non-negative, its result fits in XLEN bits.
    always_comb begin
        shifted_s = {rem_r, quo_r[XLEN-1]};
        trial_s   = shifted_s - {1'b0, divisor_r};
        if (!trial_s[XLEN]) begin
            rem_nx_s = trial_s[XLEN-1:0];
            quo_nx_s = {quo_r[XLEN-2:0], 1'b1};
        end else begin
            rem_nx_s = shifted_s[XLEN-1:0];
            quo_nx_s = {quo_r[XLEN-2:0], 1'b0};
        end
        if (op_rem_r) begin
            result_s = apply_sign(rem_nx_s, neg_r_r);
        end else begin
            result_s = apply_sign(quo_nx_s, neg_q_r);
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            quo_r     <= ZERO;
            rem_r     <= ZERO;
            divisor_r <= ZERO;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            op_rem_r  <= 1'b0;
            cnt_r     <= CNT_ZERO;
            C         <= ZERO;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (special_s) begin
                            C       <= special_c_s;
                            state_r <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            // quo_r starts as the dividend magnitude and is
                            // shifted out into rem_r one bit per step.
                            quo_r     <= a_mag_s;
                            rem_r     <= ZERO;
                            divisor_r <= b_mag_s;
                            neg_q_r   <= a_neg_s ^ b_neg_s;
                            neg_r_r   <= a_neg_s;
                            op_rem_r  <= op[1];
                            cnt_r     <= CNT_ZERO;
                            state_r   <= S_CALC;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                        end
                    end else begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                S_CALC: begin
                    quo_r <= quo_nx_s;
                    rem_r <= rem_nx_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        C       <= result_s;
                        state_r <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state_r <= S_CALC;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter. Expected results come from a reference
// model that uses plain SystemVerilog signed/unsigned division with the
// RV32M special cases layered on top.
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op_in;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] c_out;
    logic        busy;
    logic        done;

    int checks;
    int errors;
    logic [31:0] last_c;

    div_iter #(.XLEN(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op_in),
        .A    (a_in),
        .B    (b_in),
        .C    (c_out),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0] r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            r = o[1] ? a : 32'hFFFF_FFFF;
        end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = o[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            case (o)
                2'b00:   r = sa / sb;
                2'b01:   r = a / b;
                2'b10:   r = sa % sb;
                default: r = a % b;
            endcase
        end
        return r;
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drives a request at the current negedge and waits for done.
    // poke_at > 0 re-pulses start with junk operands at that cycle.
    // chain = 1 returns in the done cycle so the caller can start back-to-back.
    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int poke_at, input bit chain, input string tag);
        logic [31:0] exp_c;
        int exp_lat;
        int cyc;
        bit busy_any;
        exp_c   = model(o, a, b);
        exp_lat = model_lat(o, a, b);
        op_in = o; a_in = a; b_in = b; start = 1'b1;
        cyc = 0;
        busy_any = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (busy) busy_any = 1'b1;
            if (cyc == 1 && exp_lat != 1) check({tag, "_hold"}, c_out, last_c);
            if (cyc == poke_at) begin
                start = 1'b1;
                a_in  = 32'($urandom);
                b_in  = 32'($urandom);
                op_in = 2'($urandom_range(3));
            end
        end while (!done && cyc < 100);
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_c"}, c_out, exp_c);
        check({tag, "_busy"}, {31'd0, busy_any}, {31'd0, exp_lat != 1});
        last_c = exp_c;
        if (!chain) begin
            @(negedge clk);
            check({tag, "_done1"}, {31'd0, done}, 32'd0);
            check({tag, "_keep"}, c_out, exp_c);
        end
    endtask

    initial begin
        int dn;
        logic [1:0] ro;
        logic [31:0] ra;
        logic [31:0] rb;
        checks = 0;
        errors = 0;
        last_c = 32'd0;
        rst = 1'b1; start = 1'b0; op_in = 2'd0; a_in = 32'd0; b_in = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_c", c_out, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run(2'b01, 32'd100, 32'd7, 0, 1'b0, "divu");
        run(2'b11, 32'd100, 32'd7, 0, 1'b0, "remu");
        run(2'b00, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, "div_neg");
        run(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, "rem_neg");
        run(2'b10, 32'd7, 32'hFFFF_FFFE, 0, 1'b0, "rem_negb");
        run(2'b00, 32'h1234_5678, 32'd0, 0, 1'b0, "div_z");
        run(2'b01, 32'h1234_5678, 32'd0, 0, 1'b0, "divu_z");
        run(2'b10, 32'h1234_5678, 32'd0, 0, 1'b0, "rem_z");
        run(2'b11, 32'h1234_5678, 32'd0, 0, 1'b0, "remu_z");
        run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, "div_ovf");
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, "rem_ovf");
        run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, "divu_big");

        // start during CALC is ignored; then back-to-back in the DONE cycle
        run(2'b00, 32'd1000, 32'd33, 5, 1'b1, "poke");
        run(2'b11, 32'hDEAD_BEEF, 32'd1234, 0, 1'b1, "b2b");
        run(2'b00, 32'd5, 32'd0, 0, 1'b1, "b2b_z");
        run(2'b10, 32'hF000_0001, 32'd16, 0, 1'b0, "b2b_after");

        // reset at cycle 10 of CALC discards the operation
        op_in = 2'b01; a_in = 32'hFFFF_FFFF; b_in = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        check("mrst_c", c_out, 32'd0);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("mrst_nodone", 32'(dn), 32'd0);
        last_c = 32'd0;
        run(2'b01, 32'd81, 32'd9, 0, 1'b0, "post_rst");

        // randomized operations with biased corner operands
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(3));
            ra = 32'($urandom);
            rb = 32'($urandom);
            case ($urandom_range(7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(15));
                3: ra = 32'($urandom_range(255));
                default: ;
            endcase
            run(ro, ra, rb, 0, (i % 4) == 1, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
Multi-cycle iterative integer divider for the EX stage. It implements the RV32M DIV, DIVU, REM and REMU operations. It is the inverse arithmetic counterpart of the single-cycle adder and sits beside it in the execute unit. Operands are latched on a start pulse, one quotient bit is resolved per clock, and the result is returned with a one-cycle done strobe.

Parameters:
XLEN, 32, operand/result width in bits; the iteration count equals XLEN.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request a division; sampled only when busy=0
op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU (funct3[1:0] of the RV32M encoding)
A  input  XLEN  dividend, sampled with start
B  input  XLEN  divisor, sampled with start
C  output  XLEN  quotient or remainder as selected by op; holds until the next accepted start
busy  output  1  high while an operation is in progress (CALC state)
done  output  1  one-cycle strobe; C is valid in this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; all state updates on the rising edge of clk.
- Reset: state=IDLE, C=0, busy=0, done=0, counter=0, internal quotient/remainder registers=0. Reset has priority over start and over any in-flight operation; a partially computed result is discarded and done is not raised.
- States:
  - IDLE: busy=0, done=0.
  - CALC: busy=1, done=0.
  - DONE: busy=0, done=1 for exactly one cycle.
- Accept: start=1 at edge N while state is IDLE or DONE (busy=0) latches A, B, op. start while busy=1 is ignored; A/B/op changes during CALC have no effect.
- Operand preparation at accept:
  - Signed ops (DIV, REM): divisor and dividend use magnitudes.
  - Quotient sign = A[XLEN-1] xor B[XLEN-1].
  - Remainder sign = A[XLEN-1].
  - Unsigned ops use the operands as-is.
- Special cases are resolved at accept; the block goes directly to DONE at edge N with C loaded:
  - B=0: DIV/DIVU give C=all ones; REM/REMU give C=A.
  - Signed overflow (op=DIV or REM, A=0x80000000, B=0xFFFFFFFF): DIV gives C=0x80000000; REM gives C=0.
  - done is high in the cycle after edge N.
- Normal path: at edge N, enter CALC with counter=0.
  - Each CALC edge performs one restoring step: shift {rem,quo} left by 1; trial = rem - divisor (XLEN+1-bit subtract); if non-negative, rem=trial and quo[0]=1.
  - counter increments each step.
  - On the XLEN-th step (edge N+XLEN): apply sign correction (two's-complement negate when the sign flag is set), load C with the quotient or remainder per op, and enter DONE.
  - done=1 in the cycle after edge N+XLEN. Latency is XLEN+1 cycles from start to done.
- DONE to next state: at the following edge, go to IDLE, or accept a new start (back-to-back) and enter CALC or DONE per the rules above.
- Idle hold: C keeps its last value in IDLE and through a subsequent CALC until the new result loads.
- Width rules: all arithmetic is modulo 2^XLEN. The trial subtract is XLEN+1 bits wide to capture the borrow. The counter is wide enough to hold XLEN.

Test Plan:
- DIVU A=100, B=7 -> done exactly 33 cycles after the start edge; C=14. Repeat with REMU -> C=2.
- DIV A=0xFFFFFFF9 (-7), B=2 -> C=0xFFFFFFFD (-3). REM with the same operands -> C=0xFFFFFFFF (-1). REM A=7, B=0xFFFFFFFE -> C=1.
- Division by zero, A=0x12345678, B=0: DIV/DIVU -> C=0xFFFFFFFF; REM/REMU -> C=0x12345678. done occurs 1 cycle after start; busy never rises.
- Overflow, A=0x80000000, B=0xFFFFFFFF: DIV -> C=0x80000000; REM -> C=0. 1-cycle latency.
- start pulsed mid-CALC with different A/B -> ignored, and the first result is unchanged. A back-to-back start in the DONE cycle is accepted, and the second result appears 33 cycles later.
- rst asserted at cycle 10 of a CALC -> next cycle busy=0, done=0, C=0. No done strobe follows. A new start afterwards completes normally.
